// File: rtl/cmu_mem_server_if.sv
// Memory-port bundle between the cache miss unit (master) and cmu_mem_server (slave).
// Carries one 2*DATA_WIDTH-bit refill read or writeback write beat per request.
interface cmu_mem_server_if #(
  parameter int unsigned ADDR_WIDTH = 64,
  parameter int unsigned DATA_WIDTH = 64
);
  localparam int unsigned BEAT_W = 2 * DATA_WIDTH;
  localparam int unsigned MASK_W = BEAT_W / 8;

  logic                  ren;
  logic [ADDR_WIDTH-1:0] raddr;
  logic [BEAT_W-1:0]     rdata;
  logic                  rvalid;
  logic                  wen;
  logic [ADDR_WIDTH-1:0] waddr;
  logic [BEAT_W-1:0]     wdata;
  logic [MASK_W-1:0]     wmask;
  logic                  wvalid;
  logic                  busy;
  logic                  err;

  modport master (
    output ren, raddr, wen, waddr, wdata, wmask,
    input  rdata, rvalid, wvalid, busy, err
  );

  modport slave (
    input  ren, raddr, wen, waddr, wdata, wmask,
    output rdata, rvalid, wvalid, busy, err
  );
endinterface

// File: rtl/cmu_mem_server.sv
// Beat-level main-memory server behind the cache miss unit: DEPTH x 128-bit array, fixed LATENCY.
// Optional MEM_ADDR_CHECK_EN: out-of-range beats read 0, drop writes and pulse err with the response.
module cmu_mem_server #(
  parameter int unsigned ADDR_WIDTH = 64,
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned DEPTH      = 256,
  parameter int unsigned LATENCY    = 3
) (
  input logic             clk,
  input logic             rstn,
  cmu_mem_server_if.slave mem
);
  localparam int unsigned BEAT_W   = 2 * DATA_WIDTH;
  localparam int unsigned MASK_W   = BEAT_W / 8;
  localparam int unsigned IDX_W    = $clog2(DEPTH);
  localparam int unsigned HI_W     = ADDR_WIDTH - 4;
  localparam int unsigned CNT_W    = (LATENCY > 2) ? $clog2(LATENCY) : 1;
  localparam int unsigned CNT_INIT = (LATENCY >= 2) ? (LATENCY - 2) : 0;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic               is_rd;
  logic               req_oor;
  logic [BEAT_W-1:0]  beat_q;
  logic [BEAT_W-1:0]  rdata_q;
  logic               rvalid_q;
  logic               wvalid_q;
  logic               busy_q;
  logic               err_q;

  logic [BEAT_W-1:0]  store [DEPTH];

  logic [IDX_W-1:0]   rd_idx;
  logic [IDX_W-1:0]   wr_idx;
  logic               rd_oor;
  logic               wr_oor;
  logic               accept;
  logic               store_we;
  logic               acc_oor;
  logic [BEAT_W-1:0]  rd_beat;
  logic [BEAT_W-1:0]  wbits;
  logic               unused_addr;

  assign rd_idx = mem.raddr[4 +: IDX_W];
  assign wr_idx = mem.waddr[4 +: IDX_W];

`ifdef MEM_ADDR_CHECK_EN
  assign rd_oor = (mem.raddr[ADDR_WIDTH-1:4] >= HI_W'(DEPTH));
  assign wr_oor = (mem.waddr[ADDR_WIDTH-1:4] >= HI_W'(DEPTH));
`else
  assign rd_oor = 1'b0;
  assign wr_oor = 1'b0;
`endif

  // Low nibble and (without the check) the upper index bits never select anything
  assign unused_addr = ^{mem.raddr, mem.waddr};

  // A read beats a simultaneous write; the held write is taken in a later IDLE cycle
  assign accept   = (state == IDLE) && (mem.ren || mem.wen);
  assign store_we = rstn && (state == IDLE) && mem.wen && !mem.ren && !wr_oor;
  assign acc_oor  = mem.ren ? rd_oor : wr_oor;
  assign rd_beat  = (mem.ren && !rd_oor) ? store[rd_idx] : '0;

  always_comb begin
    wbits = '0;
    for (int i = 0; i < int'(MASK_W); i++) begin
      wbits[8*i +: 8] = {8{mem.wmask[i]}};
    end
  end

  // Writes commit at acceptance so a following read of the same beat sees them
  always_ff @(posedge clk) begin
    if (store_we) begin
      store[wr_idx] <= (store[wr_idx] & ~wbits) | (mem.wdata & wbits);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= IDLE;
      cnt      <= '0;
      is_rd    <= 1'b0;
      req_oor  <= 1'b0;
      beat_q   <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      wvalid_q <= 1'b0;
      busy_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      wvalid_q <= 1'b0;
      err_q    <= 1'b0;
      unique case (state)
        IDLE: begin
          if (accept) begin
            is_rd   <= mem.ren;
            req_oor <= acc_oor;
            beat_q  <= rd_beat;
            busy_q  <= 1'b1;
            if (LATENCY == 1) begin
              state    <= RESP;
              rvalid_q <= mem.ren;
              wvalid_q <= !mem.ren;
              rdata_q  <= rd_beat;
              err_q    <= acc_oor;
            end else begin
              state <= BUSY;
              cnt   <= CNT_W'(CNT_INIT);
            end
          end
        end
        BUSY: begin
          if (cnt == '0) begin
            state    <= RESP;
            rvalid_q <= is_rd;
            wvalid_q <= !is_rd;
            rdata_q  <= is_rd ? beat_q : '0;
            err_q    <= req_oor;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        RESP: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign mem.rdata  = rdata_q;
  assign mem.rvalid = rvalid_q;
  assign mem.wvalid = wvalid_q;
  assign mem.busy   = busy_q;
  assign mem.err    = err_q;
endmodule

// File: tb/tb_cmu_mem_server.sv
// Directed bench for cmu_mem_server (LATENCY=3, DEPTH=256): vector table plus multi-cycle sequences.
// Expectations for the out-of-range vectors follow MEM_ADDR_CHECK_EN when it is defined.
module tb_cmu_mem_server;
  localparam int unsigned AW = 64;
  localparam int unsigned DW = 64;

  logic clk;
  logic rstn;
  int   n_total;
  int   n_pass;

  cmu_mem_server_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  cmu_mem_server #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(256), .LATENCY(3)) dut (
    .clk  (clk),
    .rstn (rstn),
    .mem  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic         is_wr;
    logic [63:0]  addr;
    logic [127:0] wdata;
    logic [15:0]  wmask;
    logic [127:0] exp_rdata;
    logic         exp_err;
  } vec_t;

  vec_t vecs[14];

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_total++;
    if (got !== exp) $display("FAIL %s got=%h exp=%h", name, got, exp);
    else n_pass++;
  endtask

  // Issue one request at a negedge, then watch six cycles for its response pulse
  task automatic do_req(input logic is_wr, input logic [63:0] addr, input logic [127:0] wd,
                        input logic [15:0] wm, output int lat, output int npulse,
                        output logic [127:0] data, output logic [127:0] data_after, output logic errv);
    lat = 0; npulse = 0; data = '0; data_after = '1; errv = 1'b0;
    if (is_wr) begin
      bus.wen = 1'b1; bus.waddr = addr; bus.wdata = wd; bus.wmask = wm;
    end else begin
      bus.ren = 1'b1; bus.raddr = addr;
    end
    @(posedge clk);
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (k == 1) begin bus.ren = 1'b0; bus.wen = 1'b0; end
      if (is_wr ? bus.wvalid : bus.rvalid) begin
        npulse++;
        if (lat == 0) begin lat = k; data = bus.rdata; errv = bus.err; end
      end
      if (lat != 0 && k == lat + 1) data_after = bus.rdata;
    end
  endtask

  int           lat, np, rv_k, wv_k, wcnt;
  logic [127:0] d, da;
  logic         e;
  logic [4:0]   busy_bits, rv_bits;
  int           t_pulse[3];
  logic [127:0] d_pulse[3];

  initial begin
    n_total = 0; n_pass = 0;
    rstn = 1'b0;
    bus.ren = 1'b0; bus.raddr = '0; bus.wen = 1'b0; bus.waddr = '0; bus.wdata = '0; bus.wmask = '0;

    vecs[0]  = '{1'b1, 64'h40,   128'h0123456789ABCDEF0123456789ABCDEF, 16'hFFFF, 128'h0, 1'b0};
    vecs[1]  = '{1'b1, 64'h40,   {128{1'b1}},                           16'h000F, 128'h0, 1'b0};
    vecs[2]  = '{1'b0, 64'h40,   128'h0, 16'h0, 128'h0123456789ABCDEF01234567FFFFFFFF, 1'b0};
    vecs[3]  = '{1'b1, 64'h100,  {16{8'h16}}, 16'hFFFF, 128'h0, 1'b0};
    vecs[4]  = '{1'b1, 64'h110,  {16{8'h17}}, 16'hFFFF, 128'h0, 1'b0};
    vecs[5]  = '{1'b1, 64'h120,  {16{8'h18}}, 16'hFFFF, 128'h0, 1'b0};
    vecs[6]  = '{1'b1, 64'h0,    128'h00112233445566778899AABBCCDDEEFF, 16'hFFFF, 128'h0, 1'b0};
    vecs[7]  = '{1'b0, 64'h0,    128'h0, 16'h0, 128'h00112233445566778899AABBCCDDEEFF, 1'b0};
    vecs[8]  = '{1'b1, 64'h8,    {16{8'hCC}}, 16'hFF00, 128'h0, 1'b0};
    vecs[9]  = '{1'b0, 64'h4,    128'h0, 16'h0, 128'hCCCCCCCCCCCCCCCC8899AABBCCDDEEFF, 1'b0};
    vecs[11] = '{1'b1, 64'h10,   {16{8'hE1}}, 16'hFFFF, 128'h0, 1'b0};
`ifdef MEM_ADDR_CHECK_EN
    vecs[10] = '{1'b0, 64'h1000, 128'h0, 16'h0, 128'h0, 1'b1};
    vecs[12] = '{1'b1, 64'h1010, {16{8'h55}}, 16'hFFFF, 128'h0, 1'b1};
    vecs[13] = '{1'b0, 64'h10,   128'h0, 16'h0, {16{8'hE1}}, 1'b0};
`else
    vecs[10] = '{1'b0, 64'h1000, 128'h0, 16'h0, 128'hCCCCCCCCCCCCCCCC8899AABBCCDDEEFF, 1'b0};
    vecs[12] = '{1'b1, 64'h1010, {16{8'h55}}, 16'hFFFF, 128'h0, 1'b0};
    vecs[13] = '{1'b0, 64'h10,   128'h0, 16'h0, {16{8'h55}}, 1'b0};
`endif

    // Reset values
    repeat (2) @(negedge clk);
    chk("rst_rdata",  bus.rdata, 128'h0);
    chk("rst_rvalid", 128'(bus.rvalid), 128'h0);
    chk("rst_wvalid", 128'(bus.wvalid), 128'h0);
    chk("rst_busy",   128'(bus.busy), 128'h0);
    chk("rst_err",    128'(bus.err), 128'h0);
    rstn = 1'b1;
    @(negedge clk);

    // First read: busy over t+1..t+3, rvalid only at t+3
    busy_bits = '0; rv_bits = '0;
    bus.ren = 1'b1; bus.raddr = 64'h0;
    @(posedge clk);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      if (k == 1) bus.ren = 1'b0;
      busy_bits[k-1] = bus.busy;
      rv_bits[k-1]   = bus.rvalid;
    end
    chk("first_busy_window", 128'(busy_bits), 128'(5'b00111));
    chk("first_rvalid_window", 128'(rv_bits), 128'(5'b00100));

    // Table vectors
    for (int i = 0; i < 14; i++) begin
      do_req(vecs[i].is_wr, vecs[i].addr, vecs[i].wdata, vecs[i].wmask, lat, np, d, da, e);
      chk($sformatf("v%0d_latency", i), 128'(lat), 128'd3);
      chk($sformatf("v%0d_pulses", i), 128'(np), 128'd1);
      chk($sformatf("v%0d_err", i), 128'(e), 128'(vecs[i].exp_err));
      if (!vecs[i].is_wr) begin
        chk($sformatf("v%0d_rdata", i), d, vecs[i].exp_rdata);
        chk($sformatf("v%0d_rdata_after", i), da, 128'h0);
      end
    end

    // Held-ren refill over beats 16..18, address advanced on each rvalid
    np = 0;
    bus.ren = 1'b1; bus.raddr = 64'h100;
    @(posedge clk);
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (bus.rvalid) begin
        if (np < 3) begin t_pulse[np] = k; d_pulse[np] = bus.rdata; end
        np++;
        if (np == 1) bus.raddr = 64'h110;
        else if (np == 2) bus.raddr = 64'h120;
        else bus.ren = 1'b0;
      end
    end
    bus.ren = 1'b0;
    chk("refill_pulses", 128'(np), 128'd3);
    if (np == 3) begin
      chk("refill_first_lat", 128'(t_pulse[0]), 128'd3);
      chk("refill_gap01", 128'(t_pulse[1] - t_pulse[0]), 128'd4);
      chk("refill_gap12", 128'(t_pulse[2] - t_pulse[1]), 128'd4);
      chk("refill_beat16", d_pulse[0], {16{8'h16}});
      chk("refill_beat17", d_pulse[1], {16{8'h17}});
      chk("refill_beat18", d_pulse[2], {16{8'h18}});
    end

    // Simultaneous ren/wen: read first, write accepted in the IDLE cycle after rvalid
    rv_k = 0; wv_k = 0; wcnt = 0; d = '0;
    bus.ren = 1'b1; bus.raddr = 64'h40;
    bus.wen = 1'b1; bus.waddr = 64'h200; bus.wdata = 128'hA5A5_5A5A_0F0F_F0F0_1234_5678_9ABC_DEF0; bus.wmask = 16'hFFFF;
    @(posedge clk);
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      if (bus.rvalid) begin rv_k = k; d = bus.rdata; bus.ren = 1'b0; end
      if (bus.wvalid) begin if (wv_k == 0) wv_k = k; wcnt++; end
      if (rv_k != 0 && k == rv_k + 2) bus.wen = 1'b0;
    end
    bus.ren = 1'b0; bus.wen = 1'b0;
    chk("simul_rvalid_at", 128'(rv_k), 128'd3);
    chk("simul_rdata", d, 128'h0123456789ABCDEF01234567FFFFFFFF);
    chk("simul_wvalid_at", 128'(wv_k), 128'd7);
    chk("simul_wvalid_count", 128'(wcnt), 128'd1);
    do_req(1'b0, 64'h200, '0, '0, lat, np, d, da, e);
    chk("simul_write_data", d, 128'hA5A5_5A5A_0F0F_F0F0_1234_5678_9ABC_DEF0);

    // Reset one cycle after a read is accepted: no response, IDLE afterwards
    np = 0;
    bus.ren = 1'b1; bus.raddr = 64'h40;
    @(posedge clk);
    @(negedge clk);
    bus.ren = 1'b0;
    chk("midrst_busy_before", 128'(bus.busy), 128'h1);
    rstn = 1'b0;
    #1;
    chk("midrst_busy_in_reset", 128'(bus.busy), 128'h0);
    @(negedge clk);
    rstn = 1'b1;
    for (int k = 3; k <= 8; k++) begin
      @(negedge clk);
      if (bus.rvalid) np++;
      if (k == 3) chk("midrst_idle_after", 128'(bus.busy), 128'h0);
    end
    chk("midrst_no_rvalid", 128'(np), 128'd0);
    do_req(1'b0, 64'h40, '0, '0, lat, np, d, da, e);
    chk("midrst_recover_lat", 128'(lat), 128'd3);
    chk("midrst_recover_data", d, 128'h0123456789ABCDEF01234567FFFFFFFF);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout after %0d checks", n_total);
    $fatal(1, "timeout");
  end
endmodule

// File: doc/cmu_mem_server.md
Name: cmu_mem_server

Overview:
- Beat-level memory server directly downstream of the cache miss unit.
- Serves single 128-bit refill-read and writeback-write requests on the miss unit's memory port (ren/raddr -> rvalid/rdata; wen/waddr/wdata/wmask -> wvalid).
- Backing store is an internal DEPTH x 128-bit array with fixed, parameterised response latency.
- Used as the main-memory stage in the cache subsystem and as the memory model in cache-level benches.

Parameters:
- ADDR_WIDTH, 64, byte address width.
- DATA_WIDTH, 64, base word width; beat width is 2*DATA_WIDTH.
- DEPTH, 256, number of 128-bit beats in the array; power of two, >= 2.
- LATENCY, 3, cycles from request acceptance to response pulse; >= 1.

Ports:
- clk  in  1  clock
- rstn  in  1  asynchronous active-low reset
- ren  in  1  read request, level; may be held high across beats
- raddr  in  ADDR_WIDTH  read byte address
- rdata  out  2*DATA_WIDTH  read beat, valid while rvalid=1
- rvalid  out  1  one-cycle read-complete pulse
- wen  in  1  write request, level
- waddr  in  ADDR_WIDTH  write byte address
- wdata  in  2*DATA_WIDTH  write beat
- wmask  in  2*DATA_WIDTH/8  byte enables, bit i covers wdata[8i+7:8i]
- wvalid  out  1  one-cycle write-complete pulse
- busy  out  1  high in BUSY and RESP
- err  out  1  address error pulse (only with MEM_ADDR_CHECK_EN; otherwise tied 0)

Behaviour:
- Reset: asynchronous, rstn low.
  - rdata=0, rvalid=0, wvalid=0, busy=0, err=0; state=IDLE; latency counter=0.
  - Array contents are not reset.
- Reset mid-operation: the pending request is dropped and no response pulse is issued. A write accepted before reset stays committed.
- Beat index = addr[ADDR_WIDTH-1:4] modulo DEPTH. addr[3:0] is ignored; beats are 16-byte aligned.
- States: IDLE, BUSY, RESP.
- IDLE acceptance, when ren or wen is high on a rising edge:
  - Read: latch the array beat into the rdata holding register.
  - Write: commit the masked write to the array at the same edge.
  - Set the counter and go to BUSY.
  - If ren and wen are both high, the read wins. The write stays pending and is accepted at the first IDLE cycle after the read response.
- BUSY: count the cycles since acceptance. The request is latched, so input changes and deassertion are ignored.
- RESP:
  - Entered so that, for acceptance in cycle t, rvalid (read) or wvalid (write) is high for exactly cycle t+LATENCY.
  - rdata holds the latched beat during the rvalid cycle and returns to 0 afterwards.
  - The next cycle is IDLE at t+LATENCY+1.
  - For LATENCY=1, BUSY is skipped (IDLE -> RESP).
- Back-to-back handling:
  - The requester updates the address on the edge where it sees valid.
  - IDLE samples the new address one cycle after RESP.
  - A request still held high in IDLE is accepted as a new beat.
  - Minimum request-to-request spacing is LATENCY+1 cycles.
- Read-after-write to the same beat returns the written data, because the write commits at acceptance.
- busy = (state != IDLE).

Optional Feature:
- Macro: MEM_ADDR_CHECK_EN.
- With the macro defined:
  - A request whose addr[ADDR_WIDTH-1:4] >= DEPTH is still accepted and timed normally.
  - Reads return rdata=0.
  - Writes do not modify the array.
  - err pulses high together with the rvalid/wvalid pulse.
- Without the macro: the index wraps modulo DEPTH, and err is constant 0.

Test Plan:
- Reset, LATENCY=3: assert rstn=0 for 2 cycles -> all outputs 0, busy=0. Then read addr 0x0 in cycle t -> rvalid=1 only in cycle t+3, busy=1 in cycles t+1..t+3.
- Write then read: write waddr=0x40, wdata=0x0123...CDEF, wmask=0xFFFF. Then write waddr=0x40 with wdata all-ones, wmask=0x000F. Then read raddr=0x40 -> rdata = 0x0123...CDEF with low 4 bytes set to 0xFF; wvalid pulses once per write.
- Held ren, 3-beat refill: ren stays high with raddr 0x100, 0x110, 0x120, each updated on the rvalid edge -> exactly 3 rvalid pulses, spaced 4 cycles apart, returning beats 16, 17 and 18 in order.
- Simultaneous ren=wen=1 in IDLE -> rvalid first. The write is accepted in the IDLE cycle after that rvalid pulse, and wvalid follows LATENCY cycles later.
- Reset mid-BUSY: rstn low one cycle after a read is accepted -> no rvalid pulse; state IDLE after reset release.
- Out-of-range address 0x1000 (beat 256, DEPTH=256): with MEM_ADDR_CHECK_EN -> rdata=0 and err=1 with rvalid. Without it -> the access aliases to beat 0.
